// File: rtl/shake_absorb_padder.sv
// shake_absorb_padder: packs 64-bit message words into SHAKE128/SHAKE256 rate blocks,
// applies the SHAKE domain suffix (0x1F) and pad10*1 (0x80 on the last rate byte),
// and hands each block to the Keccak permutation core over a valid/ready handshake.
module shake_absorb_padder #(
    parameter int W        = 64,
    parameter int MAX_RATE = 1344
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          mode,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        in_data,
    input  logic                in_last,
    input  logic [3:0]          in_bytes,
    output logic                blk_valid,
    input  logic                blk_ready,
    output logic [MAX_RATE-1:0] blk_data,
    output logic [10:0]         blk_rate,
    output logic                blk_last
);

    localparam logic [10:0] RATE_SHAKE128_VEC = 11'd1344;
    localparam logic [10:0] RATE_SHAKE256_VEC = 11'd1088;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        PAD  = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [4:0]          cnt;
    logic [MAX_RATE-1:0] buffer;
    logic                pend_pad;
    logic [7:0]          pad_pos;
    logic                is128;

    logic                accept;
    logic                blk_hs;
    logic [3:0]          nbytes;
    logic [W-1:0]        word_masked;
    logic [4:0]          last_idx;
    logic                full_last;
    logic [10:0]         wr_bit;
    logic [10:0]         pad_bit;
    logic [10:0]         end_bit;

    assign accept    = in_valid & in_ready;
    assign blk_hs    = blk_valid & blk_ready;
    assign last_idx  = is128 ? 5'd20 : 5'd16;
    assign nbytes    = !in_last ? 4'd8 : ((in_bytes > 4'd8) ? 4'd8 : in_bytes);
    assign full_last = in_last && (nbytes == 4'd8) && (cnt == last_idx);
    assign wr_bit    = {cnt, 6'b0};
    assign pad_bit   = {pad_pos, 3'b0};
    assign end_bit   = is128 ? (RATE_SHAKE128_VEC - 11'd8) : (RATE_SHAKE256_VEC - 11'd8);
    assign blk_data  = buffer;

    // Zero the bytes of the incoming word that lie beyond the end of the message.
    always_comb begin
        word_masked = '0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < nbytes) begin
                word_masked[8*i +: 8] = in_data[8*i +: 8];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: a block leaves for OUT when full, or via PAD when the message ends.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = in_last ? PAD : FILL;
                end
            end
            FILL: begin
                if (accept) begin
                    if (in_last) begin
                        next_state = full_last ? OUT : PAD;
                    end else if (cnt == last_idx) begin
                        next_state = OUT;
                    end
                end
            end
            PAD: begin
                next_state = OUT;
            end
            OUT: begin
                if (blk_hs) begin
                    if (pend_pad) begin
                        next_state = PAD;
                    end else if (blk_last) begin
                        next_state = IDLE;
                    end else begin
                        next_state = FILL;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: word packing, padding, registered handshake flags and block metadata.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            buffer    <= '0;
            pend_pad  <= 1'b0;
            pad_pos   <= '0;
            is128     <= 1'b0;
            in_ready  <= 1'b0;
            blk_valid <= 1'b0;
            blk_rate  <= '0;
            blk_last  <= 1'b0;
        end else begin
            in_ready  <= (next_state == IDLE) || (next_state == FILL);
            blk_valid <= (next_state == OUT);
            case (state)
                IDLE, FILL: begin
                    if (accept) begin
                        buffer[wr_bit +: 64] <= word_masked;
                        pad_pos              <= {cnt, 3'b0} + {4'b0, nbytes};
                        if (state == IDLE) begin
                            is128    <= (mode == 2'b10);
                            blk_rate <= (mode == 2'b10) ? RATE_SHAKE128_VEC : RATE_SHAKE256_VEC;
                        end
                        if (in_last) begin
                            cnt <= '0;
                            if (full_last) begin
                                pend_pad <= 1'b1;
                            end
                        end else if (cnt == last_idx) begin
                            cnt <= '0;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                PAD: begin
                    buffer[pad_bit +: 8] <= buffer[pad_bit +: 8] | 8'h1F;
                    buffer[end_bit +: 8] <= buffer[end_bit +: 8] | 8'h80;
                    if (pad_bit == end_bit) begin
                        buffer[end_bit +: 8] <= buffer[end_bit +: 8] | 8'h9F;
                    end
                    blk_last <= 1'b1;
                end
                OUT: begin
                    if (blk_hs) begin
                        buffer   <= '0;
                        blk_last <= 1'b0;
                        pend_pad <= 1'b0;
                        pad_pos  <= '0;
                        cnt      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shake_absorb_padder.sv
// tb_shake_absorb_padder: directed tests of the SHAKE absorb padder with hand-computed blocks.
module tb_shake_absorb_padder;

    logic          clk;
    logic          rst;
    logic [1:0]    mode;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_data;
    logic          in_last;
    logic [3:0]    in_bytes;
    logic          blk_valid;
    logic          blk_ready;
    logic [1343:0] blk_data;
    logic [10:0]   blk_rate;
    logic          blk_last;

    int tests_run  = 0;
    int fail_count = 0;

    logic [1343:0] expd;
    logic [1343:0] got_data;
    logic          got_last;
    logic [10:0]   got_rate;

    shake_absorb_padder #(.W(64), .MAX_RATE(1344)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_rate  (blk_rate),
        .blk_last  (blk_last)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog in case a handshake never completes.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [63:0] pat(input int k);
        return 64'h0123_4567_89AB_CDEF ^ {32'(k), 32'(k * 7 + 3)};
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] req);
        tests_run++;
        assert (obs === req) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, req);
        end
    endtask

    task automatic check_blk(input string tag, input logic [1343:0] obs, input logic [1343:0] req);
        int k;
        tests_run++;
        assert (obs === req) else begin
            fail_count++;
            k = 0;
            while (k < 20 && obs[k*64 +: 64] === req[k*64 +: 64]) k++;
            $error("[TB] FAIL %s: word %0d observed %h expected %h", tag, k, obs[k*64 +: 64], req[k*64 +: 64]);
        end
    endtask

    // Present one word and return #1 after the edge that accepted it; in_valid stays high.
    task automatic send_word(input logic [63:0] d, input logic l, input logic [3:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        in_bytes = b;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            tests_run++;
            fail_count++;
            $error("[TB] FAIL in_ready_timeout: observed 0 expected 1");
        end
        @(posedge clk);
        #1;
    endtask

    // Wait for a block, capture it, and complete the handshake.
    task automatic get_block(output logic [1343:0] d, output logic l, output logic [10:0] r);
        int n = 0;
        @(negedge clk);
        while (!blk_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            tests_run++;
            fail_count++;
            $error("[TB] FAIL blk_valid_timeout: observed 0 expected 1");
        end
        d = blk_data;
        l = blk_last;
        r = blk_rate;
        blk_ready = 1'b1;
        @(posedge clk);
        #1;
        blk_ready = 1'b0;
    endtask

    // Short SHAKE256 message of three bytes.
    task automatic short_shake256(input string tag);
        mode = 2'b01;
        send_word(64'h1122_3344_55EF_CDAB, 1'b1, 4'd3);
        in_valid = 1'b0;
        get_block(got_data, got_last, got_rate);
        expd = '0;
        expd[31:0]      = 32'h1FEF_CDAB;
        expd[1087:1080] = 8'h80;
        check_blk({tag, "_data"}, got_data, expd);
        check_val({tag, "_rate"}, 64'(got_rate), 64'd1088);
        check_val({tag, "_last"}, 64'(got_last), 64'd1);
    endtask

    // Directed sequence.
    initial begin
        rst       = 1'b1;
        mode      = 2'b00;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        in_bytes  = '0;
        blk_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_in_ready", 64'(in_ready), 64'd0);
        check_val("reset_blk_valid", 64'(blk_valid), 64'd0);
        check_val("reset_blk_rate", 64'(blk_rate), 64'd0);
        check_blk("reset_blk_data", blk_data, '0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_val("idle_in_ready", 64'(in_ready), 64'd1);

        // Test 1: empty SHAKE128 message, block visible two cycles after accept.
        mode = 2'b10;
        send_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd0);
        in_valid = 1'b0;
        check_val("t1_in_ready_pad", 64'(in_ready), 64'd0);
        @(negedge clk);
        check_val("t1_valid_t1", 64'(blk_valid), 64'd0);
        @(negedge clk);
        check_val("t1_valid_t2", 64'(blk_valid), 64'd1);
        get_block(got_data, got_last, got_rate);
        expd = '0;
        expd[7:0]       = 8'h1F;
        expd[1343:1336] = 8'h80;
        check_blk("t1_data", got_data, expd);
        check_val("t1_rate", 64'(got_rate), 64'd1344);
        check_val("t1_last", 64'(got_last), 64'd1);
        check_val("t1_idle_ready", 64'(in_ready), 64'd1);

        // Test 2: three-byte SHAKE256 message.
        short_shake256("t2");

        // Test 3: SHAKE256, 17 full words ending exactly on the block boundary.
        mode = 2'b00;
        expd = '0;
        for (int k = 0; k < 17; k++) begin
            send_word(pat(k), (k == 16), 4'd8);
            expd[k*64 +: 64] = pat(k);
        end
        in_valid = 1'b0;
        check_val("t3_in_ready_out", 64'(in_ready), 64'd0);
        @(negedge clk);
        check_val("t3_full_latency", 64'(blk_valid), 64'd1);
        get_block(got_data, got_last, got_rate);
        check_blk("t3_blk1_data", got_data, expd);
        check_val("t3_blk1_last", 64'(got_last), 64'd0);
        check_val("t3_blk1_rate", 64'(got_rate), 64'd1088);
        check_val("t3_in_ready_pend", 64'(in_ready), 64'd0);
        get_block(got_data, got_last, got_rate);
        expd = '0;
        expd[7:0]       = 8'h1F;
        expd[1087:1080] = 8'h80;
        check_blk("t3_blk2_data", got_data, expd);
        check_val("t3_blk2_last", 64'(got_last), 64'd1);

        // Test 4: SHAKE128, suffix and final pad bit land on the same byte.
        mode = 2'b10;
        expd = '0;
        for (int k = 0; k < 20; k++) begin
            send_word(pat(k), 1'b0, 4'd8);
            expd[k*64 +: 64] = pat(k);
        end
        send_word(64'hFFEE_DDCC_BBAA_9988, 1'b1, 4'd7);
        in_valid = 1'b0;
        expd[20*64 +: 64] = 64'h9FEE_DDCC_BBAA_9988;
        get_block(got_data, got_last, got_rate);
        check_blk("t4_data", got_data, expd);
        check_val("t4_top_byte", 64'(got_data[1343:1336]), 64'h9F);
        check_val("t4_last", 64'(got_last), 64'd1);

        // Test 5: SHAKE128 two-block message with the core stalling for five cycles.
        mode = 2'b10;
        expd = '0;
        for (int k = 0; k < 21; k++) begin
            send_word(pat(k), 1'b0, 4'd8);
            expd[k*64 +: 64] = pat(k);
        end
        in_data = pat(21);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_blk("t5_stall_data", blk_data, expd);
            check_val("t5_stall_in_ready", 64'(in_ready), 64'd0);
            check_val("t5_stall_valid", 64'(blk_valid), 64'd1);
        end
        get_block(got_data, got_last, got_rate);
        check_blk("t5_blk1_data", got_data, expd);
        check_val("t5_blk1_last", 64'(got_last), 64'd0);
        expd = '0;
        for (int k = 21; k < 25; k++) begin
            send_word(pat(k), (k == 24), 4'd8);
            expd[(k-21)*64 +: 64] = pat(k);
        end
        in_valid = 1'b0;
        expd[263:256]   = 8'h1F;
        expd[1343:1336] = 8'h80;
        get_block(got_data, got_last, got_rate);
        check_blk("t5_blk2_data", got_data, expd);
        check_val("t5_blk2_last", 64'(got_last), 64'd1);

        // Test 6: reset in the middle of a message, then a fresh message.
        mode = 2'b01;
        for (int k = 0; k < 5; k++) begin
            send_word(pat(k + 40), 1'b0, 4'd8);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #2;
        check_val("t6_rst_in_ready", 64'(in_ready), 64'd0);
        check_val("t6_rst_blk_valid", 64'(blk_valid), 64'd0);
        check_val("t6_rst_blk_rate", 64'(blk_rate), 64'd0);
        check_val("t6_rst_blk_last", 64'(blk_last), 64'd0);
        check_blk("t6_rst_blk_data", blk_data, '0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_val("t6_ready_after", 64'(in_ready), 64'd1);
        short_shake256("t6_msg");

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
